// File: rtl/bayer_demosaic_px.sv
// Streaming Bayer-to-RGB demosaic: two line buffers feed a 3x3 window, then a
// bilinear interpolator; borders reflect by two so the CFA phase is preserved.
module bayer_demosaic_px #(
  parameter int DATA_W     = 8,
  parameter int DISP_WIDTH = 640,
  parameter int DISP_HIGHT = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cam_vsync,
  input  logic [1:0]          pattern,
  input  logic                data_in_valid,
  input  logic [DATA_W-1:0]   data_in,
  output logic                data_out_valid,
  output logic [3*DATA_W-1:0] data_out,
  output logic                out_sof,
  output logic                out_eol,
  output logic                overrun
);
  localparam int XW     = $clog2(DISP_WIDTH);
  localparam int YW     = $clog2(DISP_HIGHT);
  localparam int STAGES = 3;
  localparam int SW     = DATA_W + 2;
  localparam int SW2    = DATA_W + 1;
  localparam logic [XW-1:0] LAST_X = XW'(DISP_WIDTH - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(DISP_HIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;
  typedef logic [DATA_W-1:0] px_t;
  typedef struct packed { px_t t; px_t m; px_t b; } col_t;
  typedef struct packed { logic [1:0] site; logic sof; logic eol; } meta_t;
  typedef struct packed {
    px_t            c;
    logic [SW-1:0]  s4x;
    logic [SW-1:0]  s4d;
    logic [SW2-1:0] s2ew;
    logic [SW2-1:0] s2ns;
    meta_t          m;
  } st2_t;

  state_e              state_d, state_q;
  logic                vs_d, vs_q;
  logic [1:0]          pat_d, pat_q;
  logic [XW-1:0]       x_d, x_q;
  logic [YW-1:0]       y_d, y_q;
  logic                trail_d, trail_q;
  logic                ovr_d, ovr_q;
  logic [2*DATA_W-1:0] f0_d, f0_q;
  col_t [2:0]          win_d, win_q;
  meta_t               meta1_d, meta1_q;
  st2_t                st2_d, st2_q;
  logic [3*DATA_W-1:0] dout_d, dout_q;
  logic                sof_d, sof_q, eol_d, eol_q;
  logic [STAGES-1:0]   vld_pipe_d, vld_pipe_q;

  px_t           lb1_q [DISP_WIDTH];
  px_t           lb2_q [DISP_WIDTH];
  logic [XW-1:0] addr;
  px_t           rd1, rd2;
  logic          lb_we, trig, squash, vs_rise;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  col_t          ncol, fcol;

  // FLUSH reads one column ahead of the pixel it emits
  assign addr = (state_q == FLUSH && x_q != LAST_X) ? x_q + 1'b1 : x_q;
  assign rd1  = lb1_q[addr];
  assign rd2  = lb2_q[addr];
  assign vs_d = cam_vsync;
  assign vs_rise = cam_vsync & ~vs_q;

  always_comb begin
    state_d = state_q; pat_d = pat_q; x_d = x_q; y_d = y_q;
    trail_d = 1'b0; ovr_d = ovr_q; f0_d = f0_q; win_d = win_q;
    lb_we = 1'b0; trig = 1'b0; squash = 1'b0;
    ox = x_q; oy = y_q;
    ncol = '{t: rd2, m: rd1, b: data_in};
    if (y_q == YW'(1)) ncol.t = data_in;
    fcol = '{t: rd2, m: rd1, b: rd2};
    if (vs_rise) begin
      state_d = FILL; pat_d = pattern; x_d = '0; y_d = '0; ovr_d = 1'b0;
      squash = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: if (data_in_valid) ovr_d = 1'b1;
        FILL: if (data_in_valid) begin
          lb_we = 1'b1; x_d = x_q + 1'b1;
          if (x_q == LAST_X) begin x_d = '0; y_d = YW'(1); state_d = RUN; end
        end
        RUN: if (trail_q) begin
          // Last column of the line: right neighbour is reflected column W-2
          if (data_in_valid) ovr_d = 1'b1;
          trig = 1'b1; ox = LAST_X; oy = y_q - 1'b1;
          win_d = {win_q[1], win_q[2], win_q[1]};
          y_d = y_q + 1'b1;
          if (y_q == LAST_Y) begin y_d = y_q; state_d = FLUSH; end
        end else if (data_in_valid) begin
          lb_we = 1'b1; x_d = x_q + 1'b1;
          trig = (x_q != '0); ox = x_q - 1'b1; oy = y_q - 1'b1;
          if (x_q == '0) f0_d = {rd1, data_in};
          if (x_q == XW'(1)) win_d = {ncol, win_q[2], ncol};
          else               win_d = {ncol, win_q[2], win_q[1]};
          if (x_q == LAST_X) begin x_d = '0; trail_d = 1'b1; end
        end
        FLUSH: begin
          if (data_in_valid) ovr_d = 1'b1;
          trig = 1'b1; ox = x_q; oy = LAST_Y; x_d = x_q + 1'b1;
          if (x_q == '0)
            win_d = {fcol, col_t'({f0_q[2*DATA_W-1:DATA_W], f0_q[DATA_W-1:0],
                                   f0_q[2*DATA_W-1:DATA_W]}), fcol};
          else if (x_q == LAST_X) win_d = {win_q[1], win_q[2], win_q[1]};
          else                    win_d = {fcol, win_q[2], win_q[1]};
          if (x_q == LAST_X) begin x_d = '0; state_d = IDLE; end
        end
        default: state_d = IDLE;
      endcase
    end
    meta1_d.site = pat_q ^ {oy[0], ox[0]};
    meta1_d.sof  = (ox == '0) && (oy == '0);
    meta1_d.eol  = (ox == LAST_X);
    vld_pipe_d   = squash ? '0 : {vld_pipe_q[STAGES-2:0], trig};
  end

  always_comb begin
    st2_d.c    = win_q[1].m;
    st2_d.s4x  = SW'(win_q[1].t) + SW'(win_q[1].b) + SW'(win_q[0].m) + SW'(win_q[2].m);
    st2_d.s4d  = SW'(win_q[0].t) + SW'(win_q[0].b) + SW'(win_q[2].t) + SW'(win_q[2].b);
    st2_d.s2ew = SW2'(win_q[0].m) + SW2'(win_q[2].m);
    st2_d.s2ns = SW2'(win_q[1].t) + SW2'(win_q[1].b);
    st2_d.m    = meta1_q;
  end

  function automatic px_t avg4(input logic [SW-1:0] s);
    return px_t'((s + SW'(2)) >> 2);
  endfunction
  function automatic px_t avg2(input logic [SW2-1:0] s);
    return px_t'((s + SW2'(1)) >> 1);
  endfunction

  always_comb begin
    px_t r, g, b;
    r = st2_q.c; g = st2_q.c; b = st2_q.c;
    case (st2_q.m.site)
      2'd0:    begin g = avg4(st2_q.s4x); b = avg4(st2_q.s4d); end
      2'd1:    begin r = avg2(st2_q.s2ew); b = avg2(st2_q.s2ns); end
      2'd2:    begin b = avg2(st2_q.s2ew); r = avg2(st2_q.s2ns); end
      default: begin g = avg4(st2_q.s4x); r = avg4(st2_q.s4d); end
    endcase
    dout_d = {r, g, b};
    sof_d  = st2_q.m.sof & vld_pipe_q[1];
    eol_d  = st2_q.m.eol & vld_pipe_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; vs_q <= 1'b0; pat_q <= '0; x_q <= '0; y_q <= '0;
      trail_q <= 1'b0; ovr_q <= 1'b0; f0_q <= '0; win_q <= '0; meta1_q <= '0;
      st2_q <= '0; dout_q <= '0; sof_q <= 1'b0; eol_q <= 1'b0; vld_pipe_q <= '0;
    end else begin
      state_q <= state_d; vs_q <= vs_d; pat_q <= pat_d; x_q <= x_d; y_q <= y_d;
      trail_q <= trail_d; ovr_q <= ovr_d; f0_q <= f0_d; win_q <= win_d;
      meta1_q <= meta1_d; st2_q <= st2_d; dout_q <= dout_d; sof_q <= sof_d;
      eol_q <= eol_d; vld_pipe_q <= vld_pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb1_q[x_q] <= data_in;
      lb2_q[x_q] <= rd1;
    end
  end

  assign data_out_valid = vld_pipe_q[STAGES-1];
  assign data_out       = dout_q;
  assign out_sof        = sof_q;
  assign out_eol        = eol_q;
  assign overrun        = ovr_q;
endmodule

// File: tb/tb_bayer_demosaic_px.sv
// Scoreboard bench: DUT A (8b, 6x4) and DUT B (10b, 4x4) fed directed frames;
// expected pixels are queued at issue time and popped by per-DUT monitors.
module tb_bayer_demosaic_px;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_vs, a_iv, a_ov, a_sof, a_eol, a_ovr;
  logic [1:0] a_pat;
  logic [7:0] a_din;
  logic [23:0] a_dout;
  logic b_vs, b_iv, b_ov, b_sof, b_eol, b_ovr;
  logic [1:0] b_pat;
  logic [9:0] b_din;
  logic [29:0] b_dout;

  bayer_demosaic_px #(.DATA_W(8), .DISP_WIDTH(6), .DISP_HIGHT(4)) dut_a (
    .clk(clk), .rst(rst), .cam_vsync(a_vs), .pattern(a_pat),
    .data_in_valid(a_iv), .data_in(a_din), .data_out_valid(a_ov),
    .data_out(a_dout), .out_sof(a_sof), .out_eol(a_eol), .overrun(a_ovr));
  bayer_demosaic_px #(.DATA_W(10), .DISP_WIDTH(4), .DISP_HIGHT(4)) dut_b (
    .clk(clk), .rst(rst), .cam_vsync(b_vs), .pattern(b_pat),
    .data_in_valid(b_iv), .data_in(b_din), .data_out_valid(b_ov),
    .data_out(b_dout), .out_sof(b_sof), .out_eol(b_eol), .overrun(b_ovr));

  typedef struct packed { logic [29:0] d; logic sof; logic eol; } exp_t;
  exp_t exp_a[$];
  exp_t exp_b[$];
  int out_cyc_a[$];
  int acc_cyc [4][8];
  int checks = 0;
  int failures = 0;
  int b4_tbl [16] = '{103, 103, 102, 100, 103, 103, 102, 100,
                      102, 102, 101, 100, 100, 100, 100, 100};

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_ov) begin
      out_cyc_a.push_back(cyc);
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_out got=%h sof=%b eol=%b", a_dout, a_sof, a_eol);
      end else begin
        e = exp_a.pop_front();
        if ({6'b0, a_dout} !== e.d || a_sof !== e.sof || a_eol !== e.eol) begin
          failures++;
          $display("FAIL a_pixel got=%h/%b/%b want=%h/%b/%b", a_dout, a_sof, a_eol,
                   e.d[23:0], e.sof, e.eol);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_ov) begin
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_out got=%h sof=%b eol=%b", b_dout, b_sof, b_eol);
      end else begin
        e = exp_b.pop_front();
        if (b_dout !== e.d || b_sof !== e.sof || b_eol !== e.eol) begin
          failures++;
          $display("FAIL b_pixel got=%h/%b/%b want=%h/%b/%b", b_dout, b_sof, b_eol,
                   e.d, e.sof, e.eol);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  // Modes: 0 flat planes R=200/G=100/B=50, 1 all 255, 2 all 100, 3 all 1023,
  // 4 all 100 with a single 103 at (1,1).
  function automatic logic [9:0] pixv(input int mode, input logic [1:0] p, input int x, input int y);
    logic [1:0] s;
    s = p ^ {y[0], x[0]};
    case (mode)
      0: pixv = (s == 2'd0) ? 10'd200 : (s == 2'd3) ? 10'd50 : 10'd100;
      1: pixv = 10'd255;
      2: pixv = 10'd100;
      3: pixv = 10'd1023;
      default: pixv = (x == 1 && y == 1) ? 10'd103 : 10'd100;
    endcase
  endfunction

  function automatic logic [29:0] expv(input int d, input int mode, input int x, input int y);
    int r, g, b;
    case (mode)
      0: begin r = 200; g = 100; b = 50; end
      1: begin r = 255; g = 255; b = 255; end
      2: begin r = 100; g = 100; b = 100; end
      3: begin r = 1023; g = 1023; b = 1023; end
      default: begin r = 100; g = 100; b = b4_tbl[y*4 + x]; end
    endcase
    if (d == 0) expv = {6'b0, r[7:0], g[7:0], b[7:0]};
    else        expv = {r[9:0], g[9:0], b[9:0]};
  endfunction

  task automatic push_exp(input int d, input logic [29:0] v, input logic sof, input logic eol);
    exp_t e;
    e.d = v; e.sof = sof; e.eol = eol;
    if (d == 0) exp_a.push_back(e);
    else        exp_b.push_back(e);
  endtask

  task automatic push_frame(input int d, input int mode, input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        push_exp(d, expv(d, mode, x, y), x == 0 && y == 0, x == w - 1);
  endtask

  task automatic set_in(input int d, input logic vs, input logic [1:0] p, input logic iv,
                        input logic [9:0] v);
    @(negedge clk);
    if (d == 0) begin a_vs = vs; a_pat = p; a_iv = iv; a_din = v[7:0]; end
    else        begin b_vs = vs; b_pat = p; b_iv = iv; b_din = v; end
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) set_in(d, 1'b0, 2'd0, 1'b0, 10'd0);
  endtask

  task automatic vsync(input int d, input logic [1:0] p);
    set_in(d, 1'b1, p, 1'b0, 10'd0);
    set_in(d, 1'b0, p, 1'b0, 10'd0);
  endtask

  task automatic send_row(input int d, input int mode, input logic [1:0] p, input int y,
                          input int nx, input bit gaps);
    for (int x = 0; x < nx; x++) begin
      set_in(d, 1'b0, p, 1'b1, pixv(mode, p, x, y));
      acc_cyc[y][x] = cyc;
      if (gaps && x == 1) set_in(d, 1'b0, p, 1'b0, 10'd0);
    end
  endtask

  task automatic run_frame(input int d, input int mode, input logic [1:0] p, input int w,
                           input int h, input bit gaps);
    push_frame(d, mode, w, h);
    vsync(d, p);
    idle(d, 2);
    for (int y = 0; y < h; y++) begin
      send_row(d, mode, p, y, w, gaps);
      idle(d, 2);
    end
    idle(d, w + 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    a_vs = 0; a_pat = 0; a_iv = 0; a_din = 0;
    b_vs = 0; b_pat = 0; b_iv = 0; b_din = 0;
    repeat (4) @(negedge clk);
    chk("a_rst_valid", {31'b0, a_ov}, 0);
    chk("a_rst_data", {8'b0, a_dout}, 0);
    chk("a_rst_flags", {29'b0, a_sof, a_eol, a_ovr}, 0);
    chk("b_rst_valid", {31'b0, b_ov}, 0);
    chk("b_rst_data", {2'b0, b_dout}, 0);
    rst = 1'b0;
    idle(0, 3);

    // Flat planes in every CFA phase, plus latency on the first frame
    base = out_cyc_a.size();
    run_frame(0, 0, 2'd0, 6, 4, 1'b0);
    if (out_cyc_a.size() < base + 6) begin
      checks++; failures++;
      $display("FAIL lat_outputs_missing got=%0d want>=%0d", out_cyc_a.size() - base, 6);
    end else begin
      chk("lat_interior", out_cyc_a[base+1] - acc_cyc[1][2], 3);
      chk("lat_trailing", out_cyc_a[base+5] - acc_cyc[1][5], 4);
    end
    chk("ovr_clean_frame", {31'b0, a_ovr}, 0);
    run_frame(0, 0, 2'd1, 6, 4, 1'b1);
    run_frame(0, 0, 2'd2, 6, 4, 1'b0);
    run_frame(0, 0, 2'd3, 6, 4, 1'b1);
    run_frame(0, 1, 2'd3, 6, 4, 1'b0);

    // Abort mid row 2: only (0,1) escapes before the squash
    for (int x = 0; x < 6; x++) push_exp(0, expv(0, 1, x, 0), x == 0, x == 5);
    push_exp(0, expv(0, 1, 0, 1), 1'b0, 1'b0);
    vsync(0, 2'd0);
    idle(0, 2);
    send_row(0, 1, 2'd0, 0, 6, 1'b0); idle(0, 2);
    send_row(0, 1, 2'd0, 1, 6, 1'b0); idle(0, 2);
    send_row(0, 1, 2'd0, 2, 4, 1'b0);
    run_frame(0, 0, 2'd1, 6, 4, 1'b0);
    chk("ovr_after_abort", {31'b0, a_ovr}, 0);

    // Valid held across the line boundary: extra sample must be dropped
    push_frame(0, 0, 6, 4);
    vsync(0, 2'd0);
    idle(0, 2);
    send_row(0, 0, 2'd0, 0, 6, 1'b0); idle(0, 2);
    send_row(0, 0, 2'd0, 1, 6, 1'b0);
    set_in(0, 1'b0, 2'd0, 1'b1, 10'd0);
    idle(0, 2);
    send_row(0, 0, 2'd0, 2, 6, 1'b0); idle(0, 2);
    send_row(0, 0, 2'd0, 3, 6, 1'b0); idle(0, 14);
    chk("ovr_set", {31'b0, a_ovr}, 1);
    vsync(0, 2'd0);
    idle(0, 1);
    chk("ovr_cleared_by_vsync", {31'b0, a_ovr}, 0);

    // 10-bit 4x4 frames: constant, rounding/reflection probe, full scale
    run_frame(1, 2, 2'd0, 4, 4, 1'b0);
    run_frame(1, 4, 2'd0, 4, 4, 1'b1);
    run_frame(1, 3, 2'd2, 4, 4, 1'b0);
    chk("b_ovr_clean", {31'b0, b_ovr}, 0);

    idle(0, 10);
    chk("a_drained", exp_a.size(), 0);
    chk("b_drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
